// File: rtl/popcount_enum.sv
// popcount_enum: streams every WIDTH-bit vector whose population count equals
// a requested weight K, in ascending unsigned order, one per output handshake.
// The successor of each vector is computed in one cycle with Gosper's hack,
// using a trailing-zero count in place of the usual division.
module popcount_enum #(
  parameter int WIDTH = 8,
  localparam int CntWidth = $clog2(WIDTH) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [CntWidth-1:0] req_weight_i,
  output logic                vec_valid_o,
  input  logic                vec_ready_i,
  output logic [WIDTH-1:0]    vec_o,
  output logic                vec_last_o,
  output logic                err_o
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  localparam logic [WIDTH:0] One = {{WIDTH{1'b0}}, 1'b1};

  state_t              state;
  logic [WIDTH-1:0]    vec;
  logic [WIDTH-1:0]    top;
  logic                req_ready;
  logic                err;

  logic [WIDTH:0]      x_ext;
  logic [WIDTH:0]      c_ext;
  logic [WIDTH:0]      r_ext;
  logic [WIDTH:0]      tail_ext;
  logic [CntWidth-1:0] ctz;
  logic [WIDTH-1:0]    next_vec;
  logic [WIDTH-1:0]    low_ones;
  logic [WIDTH-1:0]    high_ones;
  logic                weight_bad;
  logic                last;
  logic                unused_carry;

  // Gosper successor: isolate lowest set bit, ripple it up, refill the tail.
  // The shift by ctz(c) replaces the textbook divide by c.
  always_comb begin
    x_ext = {1'b0, vec};
    c_ext = x_ext & (~x_ext + One);
    r_ext = x_ext + c_ext;
    ctz   = '0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (c_ext[i-1]) begin
        ctz = CntWidth'(i - 1);
      end
    end
    tail_ext = ((r_ext ^ x_ext) >> 2) >> ctz;
    next_vec = r_ext[WIDTH-1:0] | tail_ext[WIDTH-1:0];
  end

  // The carry out of r only appears after the final vector, which is never advanced.
  assign unused_carry = r_ext[WIDTH] ^ tail_ext[WIDTH];

  // Decode the requested weight into the first and final vectors of the sequence.
  always_comb begin
    weight_bad = int'(req_weight_i) > WIDTH;
    low_ones   = ~({WIDTH{1'b1}} << req_weight_i);
    high_ones  = ~({WIDTH{1'b1}} >> req_weight_i);
  end

  // Final vector is detected from the registered value, so it never needs r's carry.
  assign last = (state == EMIT) && (vec == top);

  // Request/emit controller with registered handshake and error outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      vec       <= '0;
      top       <= '0;
      req_ready <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid_i && req_ready) begin
            if (weight_bad) begin
              err <= 1'b1;
            end else begin
              state     <= EMIT;
              req_ready <= 1'b0;
              vec       <= low_ones;
              top       <= high_ones;
            end
          end
        end
        EMIT: begin
          if (vec_ready_i) begin
            if (last) begin
              state     <= IDLE;
              req_ready <= 1'b1;
              vec       <= '0;
              top       <= '0;
            end else begin
              vec <= next_vec;
            end
          end
        end
      endcase
    end
  end

  assign req_ready_o = req_ready;
  assign vec_valid_o = (state == EMIT);
  assign vec_o       = vec;
  assign vec_last_o  = last;
  assign err_o       = err;

endmodule

// File: tb/tb_popcount_enum.sv
// Directed bench for popcount_enum at WIDTH 4, 8 and 32.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_popcount_enum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       rv4, rr4, vv4, vr4, l4, e4;
  logic [2:0] k4;
  logic [3:0] v4;

  logic       rv8, rr8, vv8, vr8, l8, e8;
  logic [3:0] k8;
  logic [7:0] v8;

  logic        rv32, rr32, vv32, vr32, l32, e32;
  logic [5:0]  k32;
  logic [31:0] v32;

  int vectors = 0;
  int miscompares = 0;

  popcount_enum #(.WIDTH(4)) u_w4 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv4), .req_ready_o(rr4),
    .req_weight_i(k4), .vec_valid_o(vv4), .vec_ready_i(vr4), .vec_o(v4),
    .vec_last_o(l4), .err_o(e4)
  );

  popcount_enum #(.WIDTH(8)) u_w8 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv8), .req_ready_o(rr8),
    .req_weight_i(k8), .vec_valid_o(vv8), .vec_ready_i(vr8), .vec_o(v8),
    .vec_last_o(l8), .err_o(e8)
  );

  popcount_enum #(.WIDTH(32)) u_w32 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv32), .req_ready_o(rr32),
    .req_weight_i(k32), .vec_valid_o(vv32), .vec_ready_i(vr32), .vec_o(v32),
    .vec_last_o(l32), .err_o(e32)
  );

  // n-th (0-based) 8-bit value with popcount k, found by brute-force scan.
  function automatic logic [7:0] nth8(input int k, input int n);
    int cnt;
    logic [7:0] b;
    cnt = 0;
    for (int v = 0; v < 256; v++) begin
      b = v[7:0];
      if ($countones(b) == k) begin
        if (cnt == n) return b;
        cnt++;
      end
    end
    return '0;
  endfunction

  // Next combination: move the lowest movable 1 up one place, pack the rest low.
  function automatic logic [31:0] next_comb(input logic [31:0] x);
    int p;
    int m;
    logic [31:0] y;
    p = -1;
    m = 0;
    for (int i = 0; i < 31; i++) begin
      if (p < 0 && x[i] && !x[i+1]) p = i;
    end
    if (p < 0) return '0;
    for (int i = 0; i < p; i++) begin
      if (x[i]) m++;
    end
    y = x;
    y[p] = 1'b0;
    y[p+1] = 1'b1;
    for (int i = 0; i < p; i++) y[i] = (i < m);
    return y;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (rr4 !== 1'b0) begin miscompares++; $display("FAIL reset_rr4: got %b want 0", rr4); end
    vectors++; if (vv4 !== 1'b0) begin miscompares++; $display("FAIL reset_vv4: got %b want 0", vv4); end
    vectors++; if (v4 !== 4'b0000) begin miscompares++; $display("FAIL reset_v4: got %b want 0000", v4); end
    vectors++; if (l4 !== 1'b0) begin miscompares++; $display("FAIL reset_l4: got %b want 0", l4); end
    vectors++; if (e4 !== 1'b0) begin miscompares++; $display("FAIL reset_e4: got %b want 0", e4); end
    vectors++; if (vv8 !== 1'b0 || l8 !== 1'b0 || e8 !== 1'b0) begin
      miscompares++; $display("FAIL reset_w8: got vv=%b l=%b e=%b want 0 0 0", vv8, l8, e8);
    end
    vectors++; if (vv32 !== 1'b0 || l32 !== 1'b0 || e32 !== 1'b0) begin
      miscompares++; $display("FAIL reset_w32: got vv=%b l=%b e=%b want 0 0 0", vv32, l32, e32);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (rr4 !== 1'b1 || rr8 !== 1'b1 || rr32 !== 1'b1) begin
      miscompares++; $display("FAIL reset_release_ready: got %b%b%b want 111", rr4, rr8, rr32);
    end
  endtask

  task automatic test_w4_k2();
    logic [3:0] exp [6];
    exp = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100};
    rv4 = 1'b1; k4 = 3'd2; vr4 = 1'b1;
    @(negedge clk);
    rv4 = 1'b0;
    vectors++; if (rr4 !== 1'b0) begin miscompares++; $display("FAIL w4k2_busy: got rr=%b want 0", rr4); end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (vv4 !== 1'b1 || v4 !== exp[i] || l4 !== (i == 5)) begin
        miscompares++;
        $display("FAIL w4k2_vec%0d: got v=%b vec=%b last=%b want 1 %b %b", i, vv4, v4, l4, exp[i], (i == 5));
      end
      @(negedge clk);
    end
    vectors++;
    if (vv4 !== 1'b0 || rr4 !== 1'b1) begin
      miscompares++; $display("FAIL w4k2_idle: got vv=%b rr=%b want 0 1", vv4, rr4);
    end
    vr4 = 1'b0;
  endtask

  task automatic test_w4_single();
    logic [2:0] kk;
    logic [3:0] e;
    for (int c = 0; c < 2; c++) begin
      kk = (c == 0) ? 3'd0 : 3'd4;
      e  = (c == 0) ? 4'b0000 : 4'b1111;
      rv4 = 1'b1; k4 = kk; vr4 = 1'b0;
      @(negedge clk);
      rv4 = 1'b0;
      for (int h = 0; h < 2; h++) begin
        vectors++;
        if (vv4 !== 1'b1 || v4 !== e || l4 !== 1'b1) begin
          miscompares++;
          $display("FAIL w4_single_k%0d_hold%0d: got v=%b vec=%b last=%b want 1 %b 1", kk, h, vv4, v4, l4, e);
        end
        vr4 = (h == 1);
        @(negedge clk);
      end
      vectors++;
      if (vv4 !== 1'b0 || rr4 !== 1'b1) begin
        miscompares++; $display("FAIL w4_single_k%0d_idle: got vv=%b rr=%b want 0 1", kk, vv4, rr4);
      end
    end
    vr4 = 1'b0;
  endtask

  task automatic test_err();
    rv4 = 1'b1; k4 = 3'd5;
    @(negedge clk);
    rv4 = 1'b0;
    vectors++;
    if (e4 !== 1'b1 || vv4 !== 1'b0 || rr4 !== 1'b1) begin
      miscompares++; $display("FAIL err_pulse: got e=%b vv=%b rr=%b want 1 0 1", e4, vv4, rr4);
    end
    @(negedge clk);
    vectors++;
    if (e4 !== 1'b0 || vv4 !== 1'b0 || rr4 !== 1'b1) begin
      miscompares++; $display("FAIL err_clear: got e=%b vv=%b rr=%b want 0 0 1", e4, vv4, rr4);
    end
  endtask

  task automatic test_w8_random();
    int idx;
    bit done;
    bit prev_stall;
    logic [7:0] prev_v;
    logic [7:0] e;
    idx = 0; done = 1'b0; prev_stall = 1'b0; prev_v = '0;
    rv8 = 1'b1; k8 = 4'd3; vr8 = 1'b0;
    @(negedge clk);
    rv8 = 1'b0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      e = nth8(3, idx);
      vectors++;
      if (vv8 !== 1'b1 || v8 !== e || l8 !== (idx == 55) || $countones(v8) != 3) begin
        miscompares++;
        $display("FAIL w8k3_vec%0d: got v=%b vec=%b last=%b want 1 %b %b", idx, vv8, v8, l8, e, (idx == 55));
      end
      if (prev_stall) begin
        vectors++;
        if (v8 !== prev_v) begin
          miscompares++; $display("FAIL w8k3_hold%0d: got %b want %b", idx, v8, prev_v);
        end
      end
      vr8 = ($urandom_range(0, 1) == 1);
      if (vv8 && vr8) begin
        if (l8) done = 1'b1;
        idx++;
      end
      prev_stall = vv8 && !vr8;
      prev_v = v8;
      @(negedge clk);
    end
    vectors++;
    if (!done || idx != 56) begin
      miscompares++; $display("FAIL w8k3_count: got %0d (done=%b) want 56", idx, done);
    end
    vectors++;
    if (vv8 !== 1'b0 || rr8 !== 1'b1) begin
      miscompares++; $display("FAIL w8k3_idle: got vv=%b rr=%b want 0 1", vv8, rr8);
    end
    vr8 = 1'b0;
  endtask

  task automatic test_w8_abort();
    logic [7:0] e;
    rv8 = 1'b1; k8 = 4'd4; vr8 = 1'b1;
    @(negedge clk);
    rv8 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      e = nth8(4, i);
      vectors++;
      if (vv8 !== 1'b1 || v8 !== e) begin
        miscompares++; $display("FAIL w8k4_vec%0d: got v=%b vec=%b want 1 %b", i, vv8, v8, e);
      end
      @(negedge clk);
    end
    // Reset lands together with an 11th handshake; reset must win.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (vv8 !== 1'b0 || v8 !== 8'h00 || l8 !== 1'b0) begin
      miscompares++; $display("FAIL w8k4_abort: got vv=%b vec=%b last=%b want 0 00000000 0", vv8, v8, l8);
    end
    @(negedge clk);
    vectors++;
    if (rr8 !== 1'b1) begin miscompares++; $display("FAIL w8k4_ready_after_abort: got %b want 1", rr8); end
    rv8 = 1'b1; k8 = 4'd1;
    @(negedge clk);
    rv8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = 8'(1 << i);
      vectors++;
      if (vv8 !== 1'b1 || v8 !== e || l8 !== (i == 7)) begin
        miscompares++;
        $display("FAIL w8k1_vec%0d: got v=%b vec=%b last=%b want 1 %b %b", i, vv8, v8, l8, e, (i == 7));
      end
      @(negedge clk);
    end
    vectors++;
    if (vv8 !== 1'b0 || rr8 !== 1'b1) begin
      miscompares++; $display("FAIL w8k1_idle: got vv=%b rr=%b want 0 1", vv8, rr8);
    end
    vr8 = 1'b0;
  endtask

  task automatic test_w32();
    logic [31:0] e;
    rv32 = 1'b1; k32 = 6'd16; vr32 = 1'b1;
    @(negedge clk);
    e = 32'h0000_FFFF;
    for (int i = 0; i < 1000; i++) begin
      vectors++;
      if (vv32 !== 1'b1 || v32 !== e || l32 !== 1'b0) begin
        miscompares++;
        $display("FAIL w32k16_vec%0d: got v=%b vec=%h last=%b want 1 %h 0", i, vv32, v32, l32, e);
      end
      e = next_comb(e);
      // Weight and request changes mid-sequence must be ignored.
      k32 = 6'($urandom_range(0, 63));
      rv32 = ($urandom_range(0, 1) == 1);
      @(negedge clk);
    end
    rv32 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (vv32 !== 1'b0) begin miscompares++; $display("FAIL w32_abort: got vv=%b want 0", vv32); end
    vr32 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rv4 = 1'b0; vr4 = 1'b0; k4 = '0;
    rv8 = 1'b0; vr8 = 1'b0; k8 = '0;
    rv32 = 1'b0; vr32 = 1'b0; k32 = '0;
    test_reset();
    test_w4_k2();
    test_w4_single();
    test_err();
    test_w8_random();
    test_w8_abort();
    test_w32();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
